key_press_decoder: RTL
======================

KEY_PRESS_DECODER -- requirements
Module: key_press_decoder

Interface
REQ-001 Parameter CNT_DEB, default 20'd999_999, debounce qualification count (20 ms at 50 MHz).
REQ-002 Parameter CNT_LONG, default 26'd49_999_999, long-press threshold (1 s).
REQ-003 Parameter CNT_DBL, default 26'd14_999_999, double-click gap window (300 ms).
REQ-004 sys_clk  in  1  system clock, 50 MHz; the block SHALL use this single clock only.
REQ-005 sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 key_in  in  1  raw asynchronous key, active low (0 = pressed).
REQ-007 key_level  out  1  debounced key state, 1 = pressed.
REQ-008 short_flag  out  1  one-cycle pulse: short press classified.
REQ-009 long_flag  out  1  one-cycle pulse: long press classified.
REQ-010 double_flag  out  1  one-cycle pulse: double click classified.

Function
REQ-011 key_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debounce counter SHALL count cycles in which the synchronized inverted key differs from key_level, and clear to 0 on any cycle in which they match.
REQ-013 When the counter equals CNT_DEB and the mismatch persists, key_level SHALL toggle on the next edge and the counter SHALL clear; press and release are debounced identically.
REQ-014 The FSM SHALL have states IDLE, PRESS1, LONG_HOLD, WAIT_GAP, PRESS2, and SHALL consume only key_level edges.
REQ-015 IDLE: key_level rise -> PRESS1, hold counter cleared.
REQ-016 PRESS1: hold counter increments each cycle; reaching CNT_LONG while pressed -> long_flag pulse, go to LONG_HOLD; release before that -> WAIT_GAP with gap counter cleared.
REQ-017 LONG_HOLD: no flags; release -> IDLE.
REQ-018 WAIT_GAP: gap counter increments; press -> PRESS2; gap counter reaching CNT_DBL without press -> short_flag pulse, go to IDLE.
REQ-019 Press and gap expiry in the same cycle SHALL resolve to PRESS2, with no short_flag.
REQ-020 PRESS2: release -> double_flag pulse, go to IDLE; hold duration in PRESS2 SHALL be ignored (no long_flag).
REQ-021 Flags SHALL be registered, asserted for exactly one cycle in the cycle after the qualifying FSM event, and mutually exclusive.
REQ-022 Hold and gap counters SHALL be 26 bits and saturate; they SHALL never wrap.

Reset
REQ-023 On sys_rst_n low: key_level, all flags, all counters and the synchronizer SHALL be 0, with the FSM in IDLE.
REQ-024 Reset during any state SHALL discard a pending classification; no flag SHALL be emitted after release of reset until a new press completes.

Configuration
REQ-025 Macro KEY_DOUBLE_EN defined: behaviour per REQ-018 to REQ-020.
REQ-026 Macro KEY_DOUBLE_EN undefined: WAIT_GAP and PRESS2 SHALL be absent and double_flag tied to 0.
REQ-027 Macro KEY_DOUBLE_EN undefined: a release in PRESS1 SHALL pulse short_flag and return to IDLE directly.

Structure
REQ-028 Package key_pkg SHALL hold the FSM state encoding and the default CNT_DEB, CNT_LONG and CNT_DBL constants.
REQ-029 Synchronizer plus debounce SHALL be a sub-module key_debounce (key_in to key_level); the classifier FSM SHALL live in key_press_decoder.

Verification (CNT_DEB=3, CNT_LONG=40, CNT_DBL=20)
REQ-030 Press stable for 10 cycles then release -> key_level rises 2+4 cycles after the edge; one short_flag after a 21-cycle gap; no other flags.
REQ-031 Bounce key_in low/high every 2 cycles for 20 cycles -> key_level stays 0; no flags.
REQ-032 Hold pressed 60 cycles -> exactly one long_flag, 41 cycles after key_level rise; release -> no further flag.
REQ-033 Press 10, release 8, press 10, release (KEY_DOUBLE_EN) -> one double_flag after the second debounced release; no short_flag.
REQ-034 Second debounced press landing on the gap-expiry cycle -> PRESS2 entered; no short_flag.
REQ-035 Assert sys_rst_n low mid-WAIT_GAP -> all outputs 0 immediately; no short_flag after reset release.

Source files
------------

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key press decoder:
//   - default debounce / long-press / double-click gap counts (50 MHz clock)
//   - classifier FSM state encoding
//   - saturating increment helper for the 26-bit hold and gap counters
// Configuration macro: KEY_DOUBLE_EN (adds the WAIT_GAP and PRESS2 states).
// -----------------------------------------------------------------------------
package key_pkg;

  localparam logic [19:0] CNT_DEB_DEFAULT  = 20'd999_999;     // 20 ms
  localparam logic [25:0] CNT_LONG_DEFAULT = 26'd49_999_999;  // 1 s
  localparam logic [25:0] CNT_DBL_DEFAULT  = 26'd14_999_999;  // 300 ms

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_LONG_HOLD = 3'd2
`ifdef KEY_DOUBLE_EN
    ,
    ST_WAIT_GAP  = 3'd3,
    ST_PRESS2    = 3'd4
`endif
  } key_state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [25:0] sat_inc(input logic [25:0] value);
    return (&value) ? value : value + 26'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer followed by a symmetric debouncer. The raw key is
// active low; key_level is the debounced key state with 1 = pressed.
// key_level toggles only after the synchronized key has disagreed with it for
// CNT_DEB+1 consecutive cycles; any agreeing cycle restarts the count.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   key_in     in   raw asynchronous key, 0 = pressed
//   key_level  out  debounced key state, 1 = pressed (registered)
// -----------------------------------------------------------------------------
module key_debounce
  import key_pkg::*;
#(
  parameter logic [19:0] CNT_DEB = CNT_DEB_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level
);

  logic [1:0]  sync_q, sync_d;
  logic [19:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        key_pressed;

  always_comb begin
    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    sync_d      = {sync_q[0], key_in};
    cnt_d       = '0;
    level_d     = level_q;
    key_pressed = ~sync_q[1];

    if (key_pressed != level_q) begin
      if (cnt_q == CNT_DEB) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop take its pre-edge
      // value, so the synchronizer stages cannot collapse into one.
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign key_level = level_q;

endmodule

// File: rtl/key_press_decoder.sv
// -----------------------------------------------------------------------------
// key_press_decoder
// Classifies debounced key activity into short press, long press and (with
// KEY_DOUBLE_EN defined) double click. Each classification is a registered
// one-cycle pulse; at most one flag is high in any cycle.
//
// Configuration macro: KEY_DOUBLE_EN
//   defined   : release in PRESS1 opens a gap window; a second press inside
//               it is a double click, gap expiry is a short press.
//   undefined : release in PRESS1 is a short press immediately;
//               double_flag is tied to 0.
//
// Ports:
//   sys_clk      in   system clock (single clock domain)
//   sys_rst_n    in   asynchronous active-low reset
//   key_in       in   raw asynchronous key, 0 = pressed
//   key_level    out  debounced key state, 1 = pressed
//   short_flag   out  one-cycle pulse, short press
//   long_flag    out  one-cycle pulse, long press
//   double_flag  out  one-cycle pulse, double click
// -----------------------------------------------------------------------------
module key_press_decoder
  import key_pkg::*;
#(
  parameter logic [19:0] CNT_DEB  = CNT_DEB_DEFAULT,
  parameter logic [25:0] CNT_LONG = CNT_LONG_DEFAULT,
  parameter logic [25:0] CNT_DBL  = CNT_DBL_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic short_flag,
  output logic long_flag,
  output logic double_flag
);

  // A zero threshold could never be reached by an incremented counter.
  if (CNT_DEB == '0 || CNT_LONG == '0 || CNT_DBL == '0) begin : g_cfg_invalid
    $error("key_press_decoder: counter thresholds must be non-zero");
  end

  key_debounce #(
    .CNT_DEB (CNT_DEB)
  ) u_debounce (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .key_level (key_level)
  );

  key_state_e  state_q, state_d;
  logic [25:0] hold_q, hold_d, hold_inc;
  logic        short_q, short_d;
  logic        long_q, long_d;
`ifdef KEY_DOUBLE_EN
  logic [25:0] gap_q, gap_d, gap_inc;
  logic        double_q, double_d;
`endif

  // Every state is entered with key_level at the opposite value of the one it
  // waits for, so testing the level inside a state is testing for its edge.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hold_inc = sat_inc(hold_q);
    short_d  = 1'b0;
    long_d   = 1'b0;
`ifdef KEY_DOUBLE_EN
    gap_d    = gap_q;
    gap_inc  = sat_inc(gap_q);
    double_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (key_level) begin
          state_d = ST_PRESS1;
          hold_d  = '0;
        end
      end

      ST_PRESS1: begin
        // Release wins over the long threshold when both land together.
        if (!key_level) begin
`ifdef KEY_DOUBLE_EN
          state_d = ST_WAIT_GAP;
          gap_d   = '0;
`else
          short_d = 1'b1;
          state_d = ST_IDLE;
`endif
        end else begin
          hold_d = hold_inc;
          if (hold_inc == CNT_LONG) begin
            long_d  = 1'b1;
            state_d = ST_LONG_HOLD;
          end
        end
      end

      ST_LONG_HOLD: begin
        if (!key_level) begin
          state_d = ST_IDLE;
        end
      end

`ifdef KEY_DOUBLE_EN
      ST_WAIT_GAP: begin
        // A press arriving on the expiry cycle still counts as the second click.
        if (key_level) begin
          state_d = ST_PRESS2;
        end else begin
          gap_d = gap_inc;
          if (gap_inc == CNT_DBL) begin
            short_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_PRESS2: begin
        if (!key_level) begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
`ifdef KEY_DOUBLE_EN
      gap_q    <= '0;
      double_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      short_q  <= short_d;
      long_q   <= long_d;
`ifdef KEY_DOUBLE_EN
      gap_q    <= gap_d;
      double_q <= double_d;
`endif
    end
  end

  assign short_flag  = short_q;
  assign long_flag   = long_q;
`ifdef KEY_DOUBLE_EN
  assign double_flag = double_q;
`else
  assign double_flag = 1'b0;
`endif

endmodule
